mesi_bus_arbiter: RTL and testbench
===================================

Name: mesi_bus_arbiter

Overview:
- Arbitrates and sequences the shared snooping bus between NUM_CACHES per-cache MESI controllers.
- Grants one requester at a time, round-robin, and broadcasts its bus command (BusRd/BusRdX/BusUpgr) to all other caches.
- Collects the other caches' shared/flush responses, returns the C (copy-exists) signal to the requester, and fetches from memory when no cache supplies data.
- Sits between the cache FSMs and the memory port.

Parameters:
- NUM_CACHES, 4, number of requesting caches (>=2).
- OWNER_W, $clog2(NUM_CACHES), width of the owner index (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_CACHES  cache i requests the bus; held until done[i]
- req_cmd  in  NUM_CACHES*2  bus_cmd_t per cache, slice i; stable while req_valid[i]
- grant  out  NUM_CACHES  one-hot current bus owner
- done  out  NUM_CACHES  one-cycle pulse to the owner at transaction end
- bus_cmd  out  2  broadcast command; CMD_NONE when idle
- bus_owner  out  OWNER_W  index of the current owner
- snoop_shared  in  NUM_CACHES  cache i holds a valid copy (sampled in SNOOP)
- snoop_flush  in  NUM_CACHES  cache i is flushing a Modified line (sampled in SNOOP)
- c_out  out  1  copy-exists result to the owner; valid only with done
- mem_rd_req  out  1  memory read request; level signal
- mem_ack  in  1  memory data ready
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async assert):
  - state=IDLE, rr_ptr=NUM_CACHES-1, so cache 0 has first priority.
  - grant=0, done=0, bus_cmd=CMD_NONE, bus_owner=0, c_out=0, mem_rd_req=0, proto_err=0.
  - Reset asserted mid-transaction aborts it; no done is issued.
- Eligible request: req_valid[i] && req_cmd[i]!=CMD_NONE. A valid request carrying CMD_NONE is ignored.
- FSM states: IDLE, SNOOP, MEM, DONE. All outputs are registered.
- IDLE:
  - If any request is eligible, pick the first eligible index searching upward from rr_ptr+1, with wrap-around.
  - Register grant, bus_owner and bus_cmd; go to SNOOP.
  - Otherwise stay in IDLE with all outputs idle.
- SNOOP (exactly 1 cycle; grant and bus_cmd valid):
  - Compute sh = |(snoop_shared & ~grant) and fl = (snoop_flush & ~grant). The owner's own snoop lines are ignored.
  - Next state, in priority order:
    - BusUpgr -> DONE.
    - Any bit of fl set -> DONE (cache-to-cache data; memory is updated by the flush).
    - Otherwise -> MEM.
  - Register c_res = sh | (|fl).
  - Set proto_err if any of the following holds:
    - popcount(fl) > 1;
    - fl is nonzero on a BusUpgr;
    - fl is nonzero and sh has a bit set for a different cache than the flusher.
  - A protocol error does not stall the transaction.
- MEM:
  - mem_rd_req=1 until mem_ack is sampled high, then DONE on the next cycle.
  - mem_ack is ignored in every other state.
  - No timeout.
- DONE (1 cycle):
  - done[owner]=1, c_out=c_res (0 for BusRdX is allowed; the owner ignores it).
  - Clear grant, set rr_ptr=owner, go to IDLE.
  - bus_cmd returns to CMD_NONE the following cycle.
- Latency:
  - Request sampled in IDLE at cycle t: grant at t+1.
  - BusUpgr or flush case: done at t+2.
  - Memory case with mem_ack at t+2: done at t+3.
  - Back-to-back transactions: minimum 3 cycles per transaction (IDLE cycle between them).
- If req_valid drops while the requester is granted, the transaction still completes and done is pulsed anyway.
- A request arriving during a transaction waits; there is no preemption.
- Fairness: with all requesters continuously active, each cache is granted once per NUM_CACHES transactions.

Decomposition:
- mesi_pkg (shared):
  - existing mesi_states_t;
  - new bus_cmd_t {CMD_NONE=0, CMD_BUSRD=1, CMD_BUSRDX=2, CMD_BUSUPGR=3};
  - new arb_state_t {IDLE, SNOOP, MEM, DONE}.
- Sub-module rr_arbiter: purely combinational. Inputs: request vector and rr_ptr. Output: one-hot grant plus index. Reusable for other shared resources.

Test Plan:
- Single BusRd, cache 1, no sharers: req at t0 -> grant=0010 at t1, mem_rd_req at t2; mem_ack at t4 -> done[1] at t5 with c_out=0.
- BusRd from cache 0 while cache 2 asserts snoop_flush in SNOOP -> no mem_rd_req; done[0] at t+2 with c_out=1; proto_err stays 0.
- BusUpgr from cache 3 with snoop_shared=0101 -> done[3] at t+2, mem_rd_req never asserted.
- All four caches requesting continuously from reset -> grant order 0,1,2,3,0; each done separated by >=3 cycles.
- Two caches flush in the same SNOOP cycle -> proto_err rises and stays high; transaction still completes.
- rst asserted during MEM -> all outputs 0 immediately (async); no done; after release, cache 0 has first priority.

Source files
------------

// File: rtl/mesi_pkg.sv
// Shared MESI types: line states, snooping-bus commands and bus arbiter FSM states.
package mesi_pkg;

    localparam int unsigned CMD_W = 2;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_states_t;

    typedef enum logic [CMD_W-1:0] {
        CMD_NONE    = 2'd0,
        CMD_BUSRD   = 2'd1,
        CMD_BUSRDX  = 2'd2,
        CMD_BUSUPGR = 2'd3
    } bus_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        MEM   = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from ptr+1, wrapping.
module rr_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt_c,
    output logic [W-1:0] idx_c,
    output logic         found_c
);

    // Walk offsets 1..N from the pointer; the first hit wins.
    always_comb begin
        int unsigned j;
        gnt_c   = '0;
        idx_c   = '0;
        found_c = 1'b0;
        j       = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!found_c && req[j]) begin
                found_c  = 1'b1;
                gnt_c[j] = 1'b1;
                idx_c    = W'(j);
            end
        end
    end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// Snooping-bus sequencer: round-robin grant, snoop collection, memory fallback, done/C return.
module mesi_bus_arbiter
    import mesi_pkg::*;
#(
    parameter int unsigned NUM_CACHES = 4,
    parameter int unsigned OWNER_W    = $clog2(NUM_CACHES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CACHES-1:0]     req_valid,
    input  logic [NUM_CACHES*2-1:0]   req_cmd,
    output logic [NUM_CACHES-1:0]     grant,
    output logic [NUM_CACHES-1:0]     done,
    output logic [1:0]                bus_cmd,
    output logic [OWNER_W-1:0]        bus_owner,
    input  logic [NUM_CACHES-1:0]     snoop_shared,
    input  logic [NUM_CACHES-1:0]     snoop_flush,
    output logic                      c_out,
    output logic                      mem_rd_req,
    input  logic                      mem_ack,
    output logic                      proto_err
);

    arb_state_t              state, state_n;
    logic [OWNER_W-1:0]      rr_ptr, rr_ptr_n;
    logic [NUM_CACHES-1:0]   grant_q, grant_n;
    logic [NUM_CACHES-1:0]   done_q, done_n;
    bus_cmd_t                bus_cmd_q, bus_cmd_n;
    logic [OWNER_W-1:0]      owner_q, owner_n;
    logic                    c_out_q, c_out_n;
    logic                    c_res, c_res_n;
    logic                    mem_rd_q, mem_rd_n;
    logic                    err_q, err_n;

    bus_cmd_t                cmd_arr [NUM_CACHES];
    logic [NUM_CACHES-1:0]   eligible;
    logic [NUM_CACHES-1:0]   arb_gnt;
    logic [OWNER_W-1:0]      arb_idx;
    logic                    arb_found;

    logic [NUM_CACHES-1:0]   sh_vec;
    logic [NUM_CACHES-1:0]   fl;
    logic                    sh;
    logic                    any_fl;
    logic                    snoop_err;

    // Split the packed command bus and mask out requests that carry no command.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CACHES; i++) begin
            cmd_arr[i]  = bus_cmd_t'(req_cmd[2*i +: 2]);
            eligible[i] = req_valid[i] && (cmd_arr[i] != CMD_NONE);
        end
    end

    rr_arbiter #(
        .N (NUM_CACHES),
        .W (OWNER_W)
    ) u_rr (
        .req     (eligible),
        .ptr     (rr_ptr),
        .gnt_c   (arb_gnt),
        .idx_c   (arb_idx),
        .found_c (arb_found)
    );

    // Snoop responses from everyone except the owner, plus protocol sanity checks.
    always_comb begin
        sh_vec    = snoop_shared & ~grant_q;
        fl        = snoop_flush & ~grant_q;
        sh        = |sh_vec;
        any_fl    = |fl;
        snoop_err = (|(fl & (fl - NUM_CACHES'(1))))
                  || (any_fl && (bus_cmd_q == CMD_BUSUPGR))
                  || (any_fl && (|(sh_vec & ~fl)));
    end

    // Next-state and next-output logic for the bus transaction sequencer.
    always_comb begin
        state_n   = state;
        rr_ptr_n  = rr_ptr;
        grant_n   = grant_q;
        done_n    = '0;
        bus_cmd_n = bus_cmd_q;
        owner_n   = owner_q;
        c_out_n   = 1'b0;
        c_res_n   = c_res;
        mem_rd_n  = mem_rd_q;
        err_n     = err_q;
        case (state)
            IDLE: begin
                grant_n   = '0;
                bus_cmd_n = CMD_NONE;
                mem_rd_n  = 1'b0;
                if (arb_found) begin
                    grant_n   = arb_gnt;
                    owner_n   = arb_idx;
                    bus_cmd_n = cmd_arr[arb_idx];
                    state_n   = SNOOP;
                end
            end
            SNOOP: begin
                c_res_n = sh | any_fl;
                if (snoop_err) begin
                    err_n = 1'b1;
                end
                if ((bus_cmd_q == CMD_BUSUPGR) || any_fl) begin
                    state_n = DONE;
                    done_n  = grant_q;
                    c_out_n = sh | any_fl;
                end else begin
                    state_n  = MEM;
                    mem_rd_n = 1'b1;
                end
            end
            MEM: begin
                mem_rd_n = 1'b1;
                if (mem_ack) begin
                    mem_rd_n = 1'b0;
                    state_n  = DONE;
                    done_n   = grant_q;
                    c_out_n  = c_res;
                end
            end
            DONE: begin
                grant_n   = '0;
                bus_cmd_n = CMD_NONE;
                rr_ptr_n  = owner_q;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= OWNER_W'(NUM_CACHES - 1);
            grant_q   <= '0;
            done_q    <= '0;
            bus_cmd_q <= CMD_NONE;
            owner_q   <= '0;
            c_out_q   <= 1'b0;
            c_res     <= 1'b0;
            mem_rd_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            grant_q   <= grant_n;
            done_q    <= done_n;
            bus_cmd_q <= bus_cmd_n;
            owner_q   <= owner_n;
            c_out_q   <= c_out_n;
            c_res     <= c_res_n;
            mem_rd_q  <= mem_rd_n;
            err_q     <= err_n;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign bus_cmd    = bus_cmd_q;
    assign bus_owner  = owner_q;
    assign c_out      = c_out_q;
    assign mem_rd_req = mem_rd_q;
    assign proto_err  = err_q;

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Directed bench for mesi_bus_arbiter with a done/C-result scoreboard.
module tb_mesi_bus_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned OW = 2;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [2*N-1:0] req_cmd;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic [1:0]    bus_cmd;
    logic [OW-1:0] bus_owner;
    logic [N-1:0]  snoop_shared;
    logic [N-1:0]  snoop_flush;
    logic          c_out;
    logic          mem_rd_req;
    logic          mem_ack;
    logic          proto_err;

    typedef struct {
        int unsigned owner;
        logic        c;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_done_cyc = -100;

    mesi_bus_arbiter #(.NUM_CACHES(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_cmd      (req_cmd),
        .grant        (grant),
        .done         (done),
        .bus_cmd      (bus_cmd),
        .bus_owner    (bus_owner),
        .snoop_shared (snoop_shared),
        .snoop_flush  (snoop_flush),
        .c_out        (c_out),
        .mem_rd_req   (mem_rd_req),
        .mem_ack      (mem_ack),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int unsigned i, input logic [1:0] cmd);
        req_cmd[2*i +: 2] = cmd;
    endtask

    task automatic push(input int unsigned owner, input logic c);
        exp_t e;
        e.owner = owner;
        e.c     = c;
        sb.push_back(e);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (done != '0)) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("done_owner", 32'(done), 32'(1) << e.owner);
                chk("done_c_out", 32'(c_out), 32'(e.c));
                chk("done_spacing_ge3", 32'(cyc - last_done_cyc >= 3), 32'(1));
            end
            last_done_cyc = cyc;
        end
    end

    initial begin
        int seen;
        rst          = 1'b1;
        req_valid    = '0;
        req_cmd      = '0;
        snoop_shared = '0;
        snoop_flush  = '0;
        mem_ack      = 1'b0;
        step();
        step();
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_bus_cmd", 32'(bus_cmd), 32'(0));
        chk("rst_bus_owner", 32'(bus_owner), 32'(0));
        chk("rst_c_out", 32'(c_out), 32'(0));
        chk("rst_mem_rd_req", 32'(mem_rd_req), 32'(0));
        chk("rst_proto_err", 32'(proto_err), 32'(0));
        rst = 1'b0;

        // BusRd from cache 1, nobody shares: memory path, ack at t4, done at t5.
        req_valid = 4'b0010;
        set_cmd(1, 2'd1);
        push(1, 1'b0);
        step();
        chk("t1_grant", 32'(grant), 32'(4'b0010));
        chk("t1_bus_cmd", 32'(bus_cmd), 32'(1));
        chk("t1_bus_owner", 32'(bus_owner), 32'(1));
        chk("t1_no_mem_yet", 32'(mem_rd_req), 32'(0));
        step();
        chk("t1_mem_rd_t2", 32'(mem_rd_req), 32'(1));
        step();
        chk("t1_mem_rd_t3", 32'(mem_rd_req), 32'(1));
        chk("t1_no_done_t3", 32'(done), 32'(0));
        step();
        chk("t1_mem_rd_t4", 32'(mem_rd_req), 32'(1));
        mem_ack = 1'b1;
        step();
        chk("t1_done_t5", 32'(done), 32'(4'b0010));
        chk("t1_mem_rd_low", 32'(mem_rd_req), 32'(0));
        mem_ack   = 1'b0;
        req_valid = '0;
        set_cmd(1, 2'd0);
        step();
        chk("t1_idle_grant", 32'(grant), 32'(0));
        chk("t1_idle_bus_cmd", 32'(bus_cmd), 32'(0));
        chk("t1_done_pulse", 32'(done), 32'(0));

        // BusRd from cache 0, cache 2 flushes: cache-to-cache, C=1, no memory.
        req_valid = 4'b0001;
        set_cmd(0, 2'd1);
        push(0, 1'b1);
        step();
        chk("t2_grant", 32'(grant), 32'(4'b0001));
        snoop_flush = 4'b0100;
        step();
        chk("t2_done", 32'(done), 32'(4'b0001));
        chk("t2_no_mem", 32'(mem_rd_req), 32'(0));
        chk("t2_proto_err", 32'(proto_err), 32'(0));
        snoop_flush = '0;
        req_valid   = '0;
        set_cmd(0, 2'd0);
        step();

        // BusUpgr from cache 3 with caches 0 and 2 sharing.
        req_valid = 4'b1000;
        set_cmd(3, 2'd3);
        push(3, 1'b1);
        step();
        chk("t3_grant", 32'(grant), 32'(4'b1000));
        chk("t3_bus_cmd", 32'(bus_cmd), 32'(3));
        chk("t3_bus_owner", 32'(bus_owner), 32'(3));
        snoop_shared = 4'b0101;
        step();
        chk("t3_done", 32'(done), 32'(4'b1000));
        chk("t3_no_mem", 32'(mem_rd_req), 32'(0));
        snoop_shared = '0;
        req_valid    = '0;
        set_cmd(3, 2'd0);
        step();
        chk("t3_no_mem_after", 32'(mem_rd_req), 32'(0));
        chk("t3_proto_err", 32'(proto_err), 32'(0));

        // Two flushers in one snoop: sticky error, transaction still completes.
        req_valid = 4'b0010;
        set_cmd(1, 2'd1);
        push(1, 1'b1);
        step();
        chk("t5_grant", 32'(grant), 32'(4'b0010));
        snoop_flush = 4'b0101;
        step();
        chk("t5_done", 32'(done), 32'(4'b0010));
        chk("t5_err", 32'(proto_err), 32'(1));
        snoop_flush = '0;
        req_valid   = '0;
        set_cmd(1, 2'd0);
        repeat (4) step();
        chk("t5_err_sticky", 32'(proto_err), 32'(1));

        // All four requesting from reset: grants 0,1,2,3,0.
        rst       = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_cmd(i, 2'd1);
        mem_ack = 1'b1;
        step();
        chk("t4_err_cleared", 32'(proto_err), 32'(0));
        rst = 1'b0;
        push(0, 1'b0);
        push(1, 1'b0);
        push(2, 1'b0);
        push(3, 1'b0);
        push(0, 1'b0);
        seen = 0;
        for (int c = 0; c < 60 && seen < 5; c++) begin
            step();
            if (done != '0) seen++;
        end
        req_valid = '0;
        mem_ack   = 1'b0;
        for (int i = 0; i < 4; i++) set_cmd(i, 2'd0);
        chk("t4_done_count", 32'(seen), 32'(5));
        step();
        step();

        // Reset during MEM: immediate clear, no done, cache 0 first afterwards.
        req_valid = 4'b0100;
        set_cmd(2, 2'd1);
        step();
        chk("t6_grant", 32'(grant), 32'(4'b0100));
        step();
        chk("t6_mem_rd", 32'(mem_rd_req), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_grant", 32'(grant), 32'(0));
        chk("t6_async_mem_rd", 32'(mem_rd_req), 32'(0));
        chk("t6_async_bus_cmd", 32'(bus_cmd), 32'(0));
        chk("t6_async_bus_owner", 32'(bus_owner), 32'(0));
        chk("t6_async_done", 32'(done), 32'(0));
        req_valid = 4'b0101;
        set_cmd(0, 2'd3);
        set_cmd(2, 2'd3);
        step();
        step();
        chk("t6_rst_no_done", 32'(done), 32'(0));
        rst = 1'b0;
        push(0, 1'b0);
        push(2, 1'b0);
        step();
        chk("t6_first_prio", 32'(grant), 32'(4'b0001));
        step();
        chk("t6_done0", 32'(done), 32'(4'b0001));
        // Cache 1 valid with CMD_NONE must be skipped in favour of cache 2.
        req_valid = 4'b0110;
        set_cmd(0, 2'd0);
        set_cmd(1, 2'd0);
        step();
        chk("t6_idle_gap", 32'(grant), 32'(0));
        step();
        chk("t6_skip_none", 32'(grant), 32'(4'b0100));
        step();
        chk("t6_done2", 32'(done), 32'(4'b0100));
        req_valid = '0;
        set_cmd(2, 2'd0);
        repeat (3) step();
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
